// File: rtl/bsg_bitwise_op_pipe.sv
// Selectable bitwise two-operand function feeding a stages_p-deep valid/ready-in,
// valid/yumi-out pipeline. Define BSG_BITWISE_OP_PIPE_ZERO_FLAG_EN to add zero_o.
module bsg_bitwise_op_pipe #(
  parameter int unsigned width_p  = 16,
  parameter int unsigned stages_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  input  logic [2:0]         op_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
`ifdef BSG_BITWISE_OP_PIPE_ZERO_FLAG_EN
  output logic               zero_o,
`endif
  input  logic               yumi_i
);

  localparam int unsigned last_lp = stages_p - 1;

  generate
    if (stages_p == 0 || stages_p > 8 || width_p == 0) begin : g_param_check
      $error("bsg_bitwise_op_pipe: stages_p must be 1..8 and width_p must be >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    OP_NOR   = 3'd0,
    OP_OR    = 3'd1,
    OP_AND   = 3'd2,
    OP_NAND  = 3'd3,
    OP_XOR   = 3'd4,
    OP_XNOR  = 3'd5,
    OP_ANDN  = 3'd6,
    OP_PASSA = 3'd7
  } op_e;

  logic [width_p-1:0]  res_c;
  logic [stages_p-1:0] adv_c;
  logic [stages_p-1:0] v_q;
  logic [width_p-1:0]  d_q [stages_p];

  always_comb begin
    res_c = a_i;
    case (op_e'(op_i))
      OP_NOR:   res_c = ~(a_i | b_i);
      OP_OR:    res_c = a_i | b_i;
      OP_AND:   res_c = a_i & b_i;
      OP_NAND:  res_c = ~(a_i & b_i);
      OP_XOR:   res_c = a_i ^ b_i;
      OP_XNOR:  res_c = ~(a_i ^ b_i);
      OP_ANDN:  res_c = a_i & ~b_i;
      OP_PASSA: res_c = a_i;
      default:  res_c = a_i;
    endcase
  end

  // A stage may advance if it or any stage downstream of it is empty, or the consumer takes.
  always_comb begin
    logic run;
    run   = yumi_i;
    adv_c = '0;
    for (int k = int'(last_lp); k >= 0; k--) begin
      run      = run | ~v_q[k];
      adv_c[k] = run;
    end
  end

  assign ready_o = adv_c[0];
  assign v_o     = v_q[last_lp];
  assign data_o  = d_q[last_lp];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_q <= '0;
      for (int k = 0; k < int'(stages_p); k++) d_q[k] <= '0;
    end else begin
      if (adv_c[0]) begin
        v_q[0] <= v_i;
        if (v_i) d_q[0] <= res_c;
      end
      for (int k = 1; k < int'(stages_p); k++) begin
        if (adv_c[k]) begin
          v_q[k] <= v_q[k-1];
          if (v_q[k-1]) d_q[k] <= d_q[k-1];
        end
      end
    end
  end

`ifdef BSG_BITWISE_OP_PIPE_ZERO_FLAG_EN
  logic [stages_p-1:0] z_q;

  // Zero flag rides alongside the data with the same advance controls.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      z_q <= '0;
    end else begin
      if (adv_c[0] && v_i) z_q[0] <= (res_c == '0);
      for (int k = 1; k < int'(stages_p); k++) begin
        if (adv_c[k] && v_q[k-1]) z_q[k] <= z_q[k-1];
      end
    end
  end

  assign zero_o = z_q[last_lp];
`endif

`ifndef SYNTHESIS
  yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o)
    else $error("bsg_bitwise_op_pipe: yumi_i asserted while v_o=0");
`endif

endmodule

// File: tb/tb_bsg_bitwise_op_pipe.sv
// Directed bench for bsg_bitwise_op_pipe: three instances (stages 2/3/4) driven
// from vector tables and hand sequences, with an order-checking scoreboard.
module tb_bsg_bitwise_op_pipe;

  localparam int W = 16;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         v_i    [N];
  logic         ready_o[N];
  logic         v_o    [N];
  logic         yumi_i [N];
  logic [W-1:0] a_i    [N];
  logic [W-1:0] b_i    [N];
  logic [W-1:0] data_o [N];
  logic [2:0]   op_i   [N];
`ifdef BSG_BITWISE_OP_PIPE_ZERO_FLAG_EN
  logic         zero_o [N];
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[N][$];

  always #5 clk = ~clk;

  bsg_bitwise_op_pipe #(.width_p(W), .stages_p(2)) u_s2 (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i[0]), .ready_o(ready_o[0]),
    .a_i(a_i[0]), .b_i(b_i[0]), .op_i(op_i[0]), .v_o(v_o[0]), .data_o(data_o[0]),
`ifdef BSG_BITWISE_OP_PIPE_ZERO_FLAG_EN
    .zero_o(zero_o[0]),
`endif
    .yumi_i(yumi_i[0]));

  bsg_bitwise_op_pipe #(.width_p(W), .stages_p(3)) u_s3 (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i[1]), .ready_o(ready_o[1]),
    .a_i(a_i[1]), .b_i(b_i[1]), .op_i(op_i[1]), .v_o(v_o[1]), .data_o(data_o[1]),
`ifdef BSG_BITWISE_OP_PIPE_ZERO_FLAG_EN
    .zero_o(zero_o[1]),
`endif
    .yumi_i(yumi_i[1]));

  bsg_bitwise_op_pipe #(.width_p(W), .stages_p(4)) u_s4 (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i[2]), .ready_o(ready_o[2]),
    .a_i(a_i[2]), .b_i(b_i[2]), .op_i(op_i[2]), .v_o(v_o[2]), .data_o(data_o[2]),
`ifdef BSG_BITWISE_OP_PIPE_ZERO_FLAG_EN
    .zero_o(zero_o[2]),
`endif
    .yumi_i(yumi_i[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      3'd0:    return ~(a | b);
      3'd1:    return a | b;
      3'd2:    return a & b;
      3'd3:    return ~(a & b);
      3'd4:    return a ^ b;
      3'd5:    return ~(a ^ b);
      3'd6:    return a & ~b;
      default: return a;
    endcase
  endfunction

  // Scoreboard: handshakes are evaluated mid-cycle, when inputs and outputs are stable.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (v_o[i] && yumi_i[i]) begin
          check($sformatf("sb_nonempty[%0d]", i), 32'(exp_q[i].size() != 0), 32'd1);
          if (exp_q[i].size() != 0) begin
            e = exp_q[i].pop_front();
            check($sformatf("sb_data[%0d]", i), 32'(data_o[i]), 32'(e));
`ifdef BSG_BITWISE_OP_PIPE_ZERO_FLAG_EN
            check($sformatf("sb_zero[%0d]", i), 32'(zero_o[i]), 32'(e == '0));
`endif
          end
        end
        if (v_i[i] && ready_o[i]) exp_q[i].push_back(model(op_i[i], a_i[i], b_i[i]));
      end
    end
  end

  always @(negedge rst_n) begin
    for (int j = 0; j < N; j++) exp_q[j].delete();
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) begin
      v_i[i] = 1'b0; yumi_i[i] = 1'b0; a_i[i] = '0; b_i[i] = '0; op_i[i] = 3'd0;
    end
  endtask

  task automatic send(input int i, input logic [2:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b);
    v_i[i] = 1'b1; op_i[i] = op; a_i[i] = a; b_i[i] = b;
  endtask

  task automatic drain(input int i, input int budget);
    int n;
    n = 0;
    v_i[i] = 1'b0;
    while (exp_q[i].size() != 0 && n < budget) begin
      yumi_i[i] = v_o[i];
      cyc();
      n++;
    end
    yumi_i[i] = 1'b0;
    check($sformatf("drain_empty[%0d]", i), 32'(exp_q[i].size()), 32'd0);
  endtask

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{op: 3'd0, a: 16'hF0F0, b: 16'hCC00, exp: 16'h030F};
    vt[1] = '{op: 3'd1, a: 16'hF0F0, b: 16'hCC00, exp: 16'hFCF0};
    vt[2] = '{op: 3'd2, a: 16'hF0F0, b: 16'hCC00, exp: 16'hC000};
    vt[3] = '{op: 3'd3, a: 16'hF0F0, b: 16'hCC00, exp: 16'h3FFF};
    vt[4] = '{op: 3'd4, a: 16'hF0F0, b: 16'hCC00, exp: 16'h3CF0};
    vt[5] = '{op: 3'd5, a: 16'hF0F0, b: 16'hCC00, exp: 16'hC30F};
    vt[6] = '{op: 3'd6, a: 16'hF0F0, b: 16'hCC00, exp: 16'h30F0};
    vt[7] = '{op: 3'd7, a: 16'hF0F0, b: 16'hCC00, exp: 16'hF0F0};

    idle_all();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    cyc();
    cyc();
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_v_o[%0d]", i), 32'(v_o[i]), 32'd0);
      check($sformatf("rst_data_o[%0d]", i), 32'(data_o[i]), 32'd0);
      check($sformatf("rst_ready_o[%0d]", i), 32'(ready_o[i]), 32'd1);
    end
    #2 rst_n = 1'b1;
    cyc();

    // All eight functions streamed back-to-back through the 2-stage instance.
    for (int c = 0; c < 12; c++) begin
      check($sformatf("ops_v_o[c%0d]", c), 32'(v_o[0]), 32'(c >= 2 && c < 10));
      if (c >= 2 && c < 10) check($sformatf("ops_data[op%0d]", c - 2), 32'(data_o[0]), 32'(vt[c-2].exp));
      yumi_i[0] = v_o[0];
      if (c < 8) send(0, vt[c].op, vt[c].a, vt[c].b);
      else v_i[0] = 1'b0;
      #1 check($sformatf("ops_ready[c%0d]", c), 32'(ready_o[0]), 32'd1);
      cyc();
    end
    idle_all();
    drain(0, 8);

    // Asynchronous reset with two results in flight.
    send(0, 3'd7, 16'h1111, 16'h0);
    cyc();
    send(0, 3'd7, 16'h2222, 16'h0);
    cyc();
    v_i[0] = 1'b0;
    check("rstmid_pre_v_o", 32'(v_o[0]), 32'd1);
    check("rstmid_pre_data", 32'(data_o[0]), 32'h1111);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_v_o", 32'(v_o[0]), 32'd0);
    check("rstmid_data_o", 32'(data_o[0]), 32'd0);
    check("rstmid_ready_o", 32'(ready_o[0]), 32'd1);
    cyc();
    #2 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cyc();
      check($sformatf("rstmid_no_stale[c%0d]", c), 32'(v_o[0]), 32'd0);
    end

    // Back-pressure on the 3-stage instance: fourth item must stall.
    for (int k = 0; k < 4; k++) begin
      send(1, 3'd7, 16'hA000 + 16'(k), 16'h0);
      #1 check($sformatf("bp_ready[k%0d]", k), 32'(ready_o[1]), 32'(k < 3));
      if (k < 3) cyc();
    end
    for (int c = 0; c < 3; c++) begin
      cyc();
      check($sformatf("bp_hold_ready[c%0d]", c), 32'(ready_o[1]), 32'd0);
      check($sformatf("bp_hold_data[c%0d]", c), 32'(data_o[1]), 32'hA000);
    end
    yumi_i[1] = v_o[1];
    #1 check("bp_ready_on_yumi", 32'(ready_o[1]), 32'd1);
    cyc();
    drain(1, 10);

    // Bubble collapse on the 4-stage instance.
    send(2, 3'd7, 16'hB000, 16'h0);
    #1 check("bub_ready0", 32'(ready_o[2]), 32'd1);
    cyc();
    v_i[2] = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      check($sformatf("bub_latency[e%0d]", e), 32'(v_o[2]), 32'(e == 4));
      if (e < 4) cyc();
    end
    for (int k = 1; k <= 3; k++) begin
      send(2, 3'd7, 16'hB000 + 16'(k), 16'h0);
      #1 check($sformatf("bub_ready[k%0d]", k), 32'(ready_o[2]), 32'd1);
      cyc();
    end
    v_i[2] = 1'b0;
    #1 check("bub_full_ready", 32'(ready_o[2]), 32'd0);
    check("bub_full_data", 32'(data_o[2]), 32'hB000);
    drain(2, 12);

    // Full 2-stage pipe with accept and yumi every cycle.
    send(0, 3'd7, 16'hC000, 16'h0);
    cyc();
    send(0, 3'd7, 16'hC001, 16'h0);
    cyc();
    send(0, 3'd7, 16'hC002, 16'h0);
    #1 check("sim_full_ready", 32'(ready_o[0]), 32'd0);
    for (int j = 0; j < 10; j++) begin
      yumi_i[0] = v_o[0];
      send(0, 3'd7, 16'hC002 + 16'(j), 16'h0);
      #1 check($sformatf("sim_ready[j%0d]", j), 32'(ready_o[0]), 32'd1);
      check($sformatf("sim_data[j%0d]", j), 32'(data_o[0]), 32'hC000 + 32'(j));
      cyc();
    end
    idle_all();
    drain(0, 8);

`ifdef BSG_BITWISE_OP_PIPE_ZERO_FLAG_EN
    send(0, 3'd2, 16'h00FF, 16'hFF00);
    cyc();
    send(0, 3'd1, 16'h00FF, 16'hFF00);
    cyc();
    v_i[0] = 1'b0;
    check("zf_and_data", 32'(data_o[0]), 32'h0000);
    check("zf_and_zero", 32'(zero_o[0]), 32'd1);
    yumi_i[0] = v_o[0];
    cyc();
    check("zf_or_data", 32'(data_o[0]), 32'hFFFF);
    check("zf_or_zero", 32'(zero_o[0]), 32'd0);
    yumi_i[0] = v_o[0];
    cyc();
    yumi_i[0] = 1'b0;
`endif

    for (int i = 0; i < N; i++)
      check($sformatf("final_empty[%0d]", i), 32'(exp_q[i].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
